axi4_rd_burst_scheduler: RTL and testbench

- Converts one linear read command (start address, byte count) into a sequence of AXI4 INCR read bursts on the AR channel.
- Each burst is capped at 256 beats and never crosses a 4 KB boundary.
- Tracks outstanding bursts by observing the R channel handshake and reports command completion with the worst response seen.
- Sits between a DMA-style command source and an AXI4 master port; the R data consumer is a separate block.

---
 rtl/axi4_rd_burst_scheduler_pkg.sv | 40 ++++
 rtl/axi4_burst_len_calc.sv | 30 +++
 rtl/axi4_rd_burst_scheduler.sv | 161 ++++++++++++++++
 tb/tb_axi4_rd_burst_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_rd_burst_scheduler_pkg.sv
// AXI4 read burst scheduler: shared AXI4 types and constants.
// Burst/response codes, burst limits, size helper and FSM states.
package axi4_rd_burst_scheduler_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned MAX_BURST_BEATS = 256;
  localparam int unsigned BOUNDARY_4K     = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_DRAIN
  } sched_state_e;

  // AxSIZE encoding for a beat of the given byte count.
  function automatic logic [2:0] size_from_bytes(input int unsigned bytes);
    logic [2:0] sz;
    sz = 3'd0;
    case (bytes)
      1:       sz = 3'd0;
      2:       sz = 3'd1;
      4:       sz = 3'd2;
      8:       sz = 3'd3;
      16:      sz = 3'd4;
      32:      sz = 3'd5;
      64:      sz = 3'd6;
      128:     sz = 3'd7;
      default: sz = 3'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/axi4_burst_len_calc.sv
// AXI4 INCR burst length calculator.
// Picks min(remaining, 256, beats left before the next 4 KB page).
module axi4_burst_len_calc
  import axi4_rd_burst_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_P  = 32,
  parameter int unsigned BYTES_WIDTH_P = 24,
  parameter int unsigned BYTES_P       = 8
) (
  input  logic [ADDR_WIDTH_P-1:0]  addr_i,
  input  logic [BYTES_WIDTH_P-1:0] rem_i,
  output logic [8:0]               len_beats_o
);

  localparam int unsigned LOG_P = $clog2(BYTES_P);

  logic [12:0] room_bytes;
  logic [12:0] room_beats;
  logic [8:0]  cap;

  // Clamp to the AXI4 length limit, then to the page boundary.
  always_comb begin
    room_bytes  = 13'(BOUNDARY_4K) - {1'b0, addr_i[11:0]};
    room_beats  = room_bytes >> LOG_P;
    cap         = (rem_i > BYTES_WIDTH_P'(MAX_BURST_BEATS))
                  ? 9'(MAX_BURST_BEATS) : rem_i[8:0];
    len_beats_o = ({4'd0, cap} > room_beats) ? room_beats[8:0] : cap;
  end

endmodule

// File: rtl/axi4_rd_burst_scheduler.sv
// AXI4 read burst scheduler: splits a linear read into INCR bursts.
// Tracks outstanding bursts via RLAST and reports the worst RRESP.
module axi4_rd_burst_scheduler
  import axi4_rd_burst_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_P      = 32,
  parameter int unsigned DATA_WIDTH_P      = 64,
  parameter int unsigned ID_WIDTH_P        = 4,
  parameter int unsigned AXI_ID_P          = 0,
  parameter int unsigned BYTES_WIDTH_P     = 24,
  parameter int unsigned MAX_OUTSTANDING_P = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH_P-1:0]  cmd_addr,
  input  logic [BYTES_WIDTH_P-1:0] cmd_bytes,
  output logic [ID_WIDTH_P-1:0]    arid,
  output logic [ADDR_WIDTH_P-1:0]  araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic                     rvalid,
  input  logic                     rready,
  input  logic                     rlast,
  input  logic [1:0]               rresp,
  output logic                     done_valid,
  output logic [1:0]               done_resp,
  output logic                     busy
);

  localparam int unsigned BYTES_P = DATA_WIDTH_P / 8;
  localparam int unsigned LOG_P   = $clog2(BYTES_P);
  localparam int unsigned OW_P    = $clog2(MAX_OUTSTANDING_P + 1);

  sched_state_e state_q, state_d;

  logic [ADDR_WIDTH_P-1:0]  addr_q, addr_d;
  logic [BYTES_WIDTH_P-1:0] rem_q, rem_d;
  logic [8:0]               len_q, len_d;
  logic [ADDR_WIDTH_P-1:0]  araddr_q, araddr_d;
  logic [7:0]               arlen_q, arlen_d;
  logic [OW_P-1:0]          out_q, out_d;
  logic [1:0]               resp_q, resp_d;

  logic [8:0]               calc_len;
  logic [BYTES_WIDTH_P-1:0] cmd_beats;
  logic [ADDR_WIDTH_P-1:0]  cmd_addr_al;
  logic                     ar_hs;
  logic                     r_beat;
  logic                     r_end;

  axi4_burst_len_calc #(
    .ADDR_WIDTH_P  (ADDR_WIDTH_P),
    .BYTES_WIDTH_P (BYTES_WIDTH_P),
    .BYTES_P       (BYTES_P)
  ) u_len_calc (
    .addr_i      (addr_q),
    .rem_i       (rem_q),
    .len_beats_o (calc_len)
  );

  assign cmd_beats   = cmd_bytes >> LOG_P;
  assign cmd_addr_al = (cmd_addr >> LOG_P) << LOG_P;

  assign arid      = ID_WIDTH_P'(AXI_ID_P);
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = size_from_bytes(BYTES_P);
  assign arburst   = BURST_INCR;
  assign arvalid   = (state_q == ST_ISSUE) &&
                     (out_q < OW_P'(MAX_OUTSTANDING_P));
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done_valid = (state_q == ST_DRAIN) && (out_q == '0);
  assign done_resp = resp_q;

  assign ar_hs  = arvalid & arready;
  assign r_beat = rvalid & rready;
  assign r_end  = r_beat & rlast & (out_q != '0);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      out_q    <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      out_q    <= out_d;
      resp_q   <= resp_d;
    end
  end

  // Next-state: command split, burst issue and completion tracking.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    len_d    = len_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    out_d    = out_q;
    resp_d   = resp_q;

    if (state_q != ST_IDLE && r_beat && rresp > resp_q) begin
      resp_d = rresp;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr_al;
          rem_d   = cmd_beats;
          resp_d  = RESP_OKAY;
          state_d = (cmd_beats == '0) ? ST_DRAIN : ST_CALC;
        end
      end
      ST_CALC: begin
        len_d    = calc_len;
        araddr_d = addr_q;
        arlen_d  = 8'(calc_len - 9'd1);
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ar_hs) begin
          addr_d  = addr_q + (ADDR_WIDTH_P'(len_q) << LOG_P);
          rem_d   = rem_q - BYTES_WIDTH_P'(len_q);
          state_d = (rem_q == BYTES_WIDTH_P'(len_q))
                    ? ST_DRAIN : ST_CALC;
        end
      end
      ST_DRAIN: begin
        if (out_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case ({ar_hs, r_end})
      2'b10:   out_d = out_q + OW_P'(1);
      2'b01:   out_d = out_q - OW_P'(1);
      default: out_d = out_q;
    endcase
  end

endmodule

// File: tb/tb_axi4_rd_burst_scheduler.sv
// Testbench for axi4_rd_burst_scheduler.
// Directed commands; AR and done monitors check against queued expectations.
module tb_axi4_rd_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_bytes;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [1:0]  rresp;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        busy;

  int vectors = 0;
  int fails   = 0;
  int ar_seen = 0;
  int done_seen = 0;

  logic [39:0] exp_ar[$];
  logic [1:0]  exp_done[$];

  always #5 clk = ~clk;

  axi4_rd_burst_scheduler #(
    .ADDR_WIDTH_P      (32),
    .DATA_WIDTH_P      (64),
    .ID_WIDTH_P        (4),
    .AXI_ID_P          (0),
    .BYTES_WIDTH_P     (24),
    .MAX_OUTSTANDING_P (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_bytes  (cmd_bytes),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rvalid     (rvalid),
    .rready     (rready),
    .rlast      (rlast),
    .rresp      (rresp),
    .done_valid (done_valid),
    .done_resp  (done_resp),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // AR monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && arvalid && arready) begin
      ar_seen++;
      if (exp_ar.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL ar_unexpected: got addr 0x%0h len %0d, expected none",
                 araddr, arlen);
      end else begin
        logic [39:0] e;
        e = exp_ar.pop_front();
        check("ar_addr", 64'(araddr), 64'(e[39:8]));
        check("ar_len", 64'(arlen), 64'(e[7:0]));
        check("ar_size", 64'(arsize), 64'd3);
        check("ar_burst", 64'(arburst), 64'd1);
        check("ar_id", 64'(arid), 64'd0);
      end
    end
  end

  // Done monitor.
  always @(negedge clk) begin
    if (rst_n && done_valid) begin
      done_seen++;
      if (exp_done.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL done_unexpected: got resp %0d, expected none",
                 done_resp);
      end else begin
        logic [1:0] e;
        e = exp_done.pop_front();
        check("done_resp", 64'(done_resp), 64'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [23:0] b);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_bytes = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      vectors++;
      fails++;
      $display("FAIL cmd_accept: got cmd_ready 0, expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_ar(input int n);
    int k;
    k = 0;
    while (ar_seen < n && k < 400) begin
      step();
      k++;
    end
    if (ar_seen < n) begin
      vectors++;
      fails++;
      $display("FAIL ar_timeout: got %0d ARs, expected %0d", ar_seen, n);
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_seen < n && k < budget) begin
      step();
      k++;
    end
    if (done_seen < n) begin
      vectors++;
      fails++;
      $display("FAIL done_timeout: got %0d dones, expected %0d", done_seen, n);
    end
  endtask

  // One R burst of n beats; beat bad_idx carries bad_resp.
  task automatic send_burst(input int n, input int bad_idx,
                            input logic [1:0] bad_resp);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rready = 1'b1;
      rlast  = (i == n - 1);
      rresp  = (i == bad_idx) ? bad_resp : 2'b00;
      step();
    end
    rvalid = 1'b0;
    rready = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_bytes = '0;
    arready = 1'b1;
    rvalid = 1'b0;
    rready = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_done_resp", 64'(done_resp), 64'd0);
    step();

    // Basic single burst.
    exp_ar.push_back({32'h0000, 8'd7});
    exp_done.push_back(2'b00);
    send_cmd(32'h0000, 24'd64);
    wait_ar(1);
    send_burst(8, -1, 2'b00);
    wait_done(1, 20);
    step();
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    step();

    // 4 KB split.
    exp_ar.push_back({32'h0FF0, 8'd1});
    exp_ar.push_back({32'h1000, 8'd5});
    exp_done.push_back(2'b00);
    send_cmd(32'h0FF0, 24'd64);
    wait_ar(3);
    send_burst(2, -1, 2'b00);
    send_burst(6, -1, 2'b00);
    wait_done(2, 20);

    // Max length bursts.
    exp_ar.push_back({32'h0000, 8'd255});
    exp_ar.push_back({32'h0800, 8'd255});
    exp_done.push_back(2'b00);
    send_cmd(32'h0000, 24'd4096);
    wait_ar(5);
    send_burst(256, -1, 2'b00);
    send_burst(256, -1, 2'b00);
    wait_done(3, 20);

    // Outstanding limit.
    base = ar_seen;
    for (int i = 0; i < 6; i++) begin
      exp_ar.push_back({32'(i * 32'h800), 8'd255});
    end
    exp_done.push_back(2'b00);
    send_cmd(32'h0000, 24'd12288);
    wait_ar(base + 4);
    repeat (10) step();
    @(negedge clk);
    check("limit_ar_count", 64'(ar_seen - base), 64'd4);
    check("limit_arvalid", 64'(arvalid), 64'd0);
    step();
    send_burst(1, -1, 2'b00);
    wait_ar(base + 5);
    send_burst(1, -1, 2'b00);
    wait_ar(base + 6);
    for (int i = 0; i < 4; i++) begin
      send_burst(1, -1, 2'b00);
    end
    wait_done(4, 20);

    // SLVERR among OKAY beats.
    exp_ar.push_back({32'h0000, 8'd3});
    exp_done.push_back(2'b10);
    send_cmd(32'h0000, 24'd32);
    wait_ar(ar_seen + 1);
    send_burst(4, 1, 2'b10);
    wait_done(5, 20);

    // DECERR.
    exp_ar.push_back({32'h0100, 8'd1});
    exp_done.push_back(2'b11);
    send_cmd(32'h0100, 24'd16);
    wait_ar(ar_seen + 1);
    send_burst(2, 1, 2'b11);
    wait_done(6, 20);

    // Zero length: no AR, quick OKAY completion.
    base = ar_seen;
    exp_done.push_back(2'b00);
    send_cmd(32'h0040, 24'd0);
    wait_done(7, 2);
    repeat (3) step();
    check("zero_no_ar", 64'(ar_seen - base), 64'd0);

    // Backpressure then reset mid-ISSUE.
    arready = 1'b0;
    send_cmd(32'h2000, 24'd32);
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_arvalid", 64'(arvalid), 64'd1);
      check("bp_araddr", 64'(araddr), 64'h2000);
      check("bp_arlen", 64'(arlen), 64'd3);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    arready = 1'b1;
    @(negedge clk);
    check("rst_mid_arvalid", 64'(arvalid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    step();

    check("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
